// File: rtl/board_mem_if.sv
// board_mem_if: burst, display and collapse signals between Game/video clients and board_mem
// master: Game/video side (drives requests, reads data and status)
// slave : board_mem (returns cell data, row_full, busy, done)
interface board_mem_if #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 3,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS)
);
    logic              start;
    logic              write_enable;
    logic              cont;
    logic [ROW_W-1:0]  addr;
    logic [CELL_W-1:0] data_in;
    logic [CELL_W-1:0] data_out;
    logic [ROW_W-1:0]  disp_row;
    logic [COL_W-1:0]  disp_col;
    logic [CELL_W-1:0] disp_data;
    logic [ROWS-1:0]   row_full;
    logic              collapse_req;
    logic [ROW_W-1:0]  collapse_row;
    logic              busy;
    logic              done;

    modport master (
        output start, write_enable, cont, addr, data_in, disp_row, disp_col, collapse_req, collapse_row,
        input  data_out, disp_data, row_full, busy, done
    );

    modport slave (
        input  start, write_enable, cont, addr, data_in, disp_row, disp_col, collapse_req, collapse_row,
        output data_out, disp_data, row_full, busy, done
    );
endinterface

// File: rtl/board_mem.sv
// board_mem: parametrised playfield store with burst port, display port, row_full flags and row-collapse engine
// clk/reset : single clock, asynchronous active-high reset
// bus       : slave side of board_mem_if (burst start/cont, display read, collapse control and status)
module board_mem #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 3,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS)
) (
    input  logic       clk,
    input  logic       reset,
    board_mem_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            r_state, w_next;
    logic [CELL_W-1:0] r_cells [ROWS][COLS];
    logic [ROW_W-1:0]  r_row_ptr, r_cur;
    logic [COL_W-1:0]  r_col_ptr;
    logic              r_writing, r_done;
    logic              w_busy, w_row_ok, w_accept, w_write;
    logic [ROWS-1:0]   w_full;

    assign w_row_ok = int'(r_row_ptr) < ROWS;
    assign w_accept = (r_state == IDLE) && bus.collapse_req && (int'(bus.collapse_row) < ROWS);
    // Burst writes are gated on IDLE so they can never race the shifting rows
    assign w_write  = bus.cont && !bus.start && r_writing && w_row_ok && (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_accept ? SHIFT : IDLE) : ((r_cur == '0) ? IDLE : SHIFT);
    end

    always_comb begin
        w_busy = (r_state == SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == SHIFT) && (r_cur == '0);
            if (w_accept)
                r_cur <= bus.collapse_row;
            else if ((r_state == SHIFT) && (r_cur != '0))
                r_cur <= r_cur - ROW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_ptr <= '0;
            r_col_ptr <= '0;
            r_writing <= 1'b0;
        end else if (bus.start) begin
            r_row_ptr <= bus.addr;
            r_col_ptr <= '0;
            r_writing <= bus.write_enable;
        end else if (bus.cont) begin
            r_col_ptr <= (r_col_ptr == COL_W'(COLS - 1)) ? '0 : r_col_ptr + COL_W'(1);
        end
    end

    // One row moves down per SHIFT cycle, walking upward from the removed row to row 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_cells[r][c] <= '0;
        end else if (r_state == SHIFT) begin
            for (int c = 0; c < COLS; c++)
                r_cells[r_cur][c] <= (r_cur == '0) ? '0 : r_cells[r_cur - ROW_W'(1)][c];
        end else if (w_write) begin
            r_cells[r_row_ptr][r_col_ptr] <= bus.data_in;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_full[r] = 1'b1;
            for (int c = 0; c < COLS; c++)
                w_full[r] = w_full[r] & (|r_cells[r][c]);
        end
    end

    assign bus.data_out  = w_row_ok ? r_cells[r_row_ptr][r_col_ptr] : '0;
    assign bus.disp_data = ((int'(bus.disp_row) < ROWS) && (int'(bus.disp_col) < COLS))
                         ? r_cells[bus.disp_row][bus.disp_col] : '0;
    assign bus.row_full  = w_full;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_board_mem.sv
// tb_board_mem: directed self-checking bench for board_mem
module tb_board_mem;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   nz;

    board_mem_if #(.ROWS(20), .COLS(10), .CELL_W(3)) bus ();
    board_mem #(.ROWS(20), .COLS(10), .CELL_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dchk(input string tag, input int r, input int c, input int exp);
        bus.disp_row = 5'(r);
        bus.disp_col = 4'(c);
        #1;
        chk(tag, 32'(bus.disp_data), 32'(exp));
    endtask

    // val 0 selects the 1..7,1,2,3 pattern; column zc (if in range) is written as 0
    task automatic burst_write(input int row, input int val, input int zc);
        bus.start = 1'b1;
        bus.write_enable = 1'b1;
        bus.addr = 5'(row);
        tick;
        bus.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.data_in = (c == zc) ? 3'd0 : ((val == 0) ? 3'((c % 7) + 1) : 3'(val));
            bus.cont = 1'b1;
            tick;
        end
        bus.cont = 1'b0;
        bus.write_enable = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            tick;
            cnt++;
        end
    endtask

    initial begin
        bus.start = 0; bus.write_enable = 0; bus.cont = 0; bus.addr = 0; bus.data_in = 0;
        bus.disp_row = 0; bus.disp_col = 0; bus.collapse_req = 0; bus.collapse_row = 0;
        tick; tick;
        reset = 1'b0;
        tick;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_full", 32'(bus.row_full), 0);

        burst_write(5, 0, -1);
        bus.start = 1'b1; bus.write_enable = 1'b0; bus.addr = 5'd5;
        tick;
        bus.start = 1'b0;
        chk("rd5_c0", 32'(bus.data_out), 1);
        for (int i = 1; i < 10; i++) begin
            bus.cont = 1'b1;
            tick;
            chk($sformatf("rd5_c%0d", i), 32'(bus.data_out), 32'((i % 7) + 1));
        end
        tick;
        chk("rd5_wrap", 32'(bus.data_out), 1);
        bus.cont = 1'b0;

        burst_write(19, 5, -1);
        burst_write(18, 4, 3);
        chk("full_mask1", 32'(bus.row_full), (32'd1 << 19) | (32'd1 << 5));
        dchk("disp_19_9", 19, 9, 5);
        dchk("disp_18_3", 18, 3, 0);
        dchk("disp_row_oor", 20, 0, 0);
        dchk("disp_col_oor", 19, 10, 0);

        burst_write(17, 1, -1);
        burst_write(18, 2, -1);
        burst_write(19, 3, -1);
        bus.collapse_req = 1'b1; bus.collapse_row = 5'd19;
        tick;
        bus.collapse_req = 1'b0;
        wait_idle(n);
        chk("c19_busy_cycles", 32'(n), 20);
        chk("c19_done", 32'(bus.done), 1);
        tick;
        chk("c19_done_pulse", 32'(bus.done), 0);
        dchk("c19_r19", 19, 0, 2);
        dchk("c19_r18", 18, 9, 1);
        dchk("c19_r17", 17, 4, 0);
        dchk("c19_r6", 6, 2, 3);
        dchk("c19_r0", 0, 0, 0);
        chk("full_mask2", 32'(bus.row_full), (32'd1 << 19) | (32'd1 << 18) | (32'd1 << 6));

        burst_write(0, 7, -1);
        chk("r0_full", 32'(bus.row_full[0]), 1);
        bus.collapse_req = 1'b1; bus.collapse_row = 5'd0;
        tick;
        chk("c0_busy", 32'(bus.busy), 1);
        tick;
        chk("c0_busy_end", 32'(bus.busy), 0);
        chk("c0_done", 32'(bus.done), 1);
        bus.collapse_req = 1'b0;
        tick;
        chk("c0_no_extra", 32'(bus.busy), 0);
        chk("c0_done_low", 32'(bus.done), 0);
        dchk("c0_r0", 0, 5, 0);

        bus.collapse_req = 1'b1; bus.collapse_row = 5'd3;
        tick;
        bus.collapse_req = 1'b0;
        bus.start = 1'b1; bus.write_enable = 1'b1; bus.addr = 5'd10;
        tick;
        bus.start = 1'b0;
        bus.cont = 1'b1; bus.data_in = 3'd5;
        tick; tick;
        bus.cont = 1'b0;
        chk("c3_busy", 32'(bus.busy), 1);
        wait_idle(n);
        chk("c3_busy_tail", 32'(n), 1);
        bus.cont = 1'b1; bus.data_in = 3'd6;
        tick;
        bus.cont = 1'b0; bus.write_enable = 1'b0;
        dchk("blk_r10_c0", 10, 0, 0);
        dchk("blk_r10_c1", 10, 1, 0);
        dchk("blk_r10_c2", 10, 2, 6);

        bus.start = 1'b1; bus.write_enable = 1'b1; bus.addr = 5'd2;
        tick;
        bus.start = 1'b0;
        bus.cont = 1'b1; bus.data_in = 3'd4;
        bus.collapse_req = 1'b1; bus.collapse_row = 5'd0;
        tick;
        bus.cont = 1'b0; bus.collapse_req = 1'b0; bus.write_enable = 1'b0;
        chk("same_cyc_busy", 32'(bus.busy), 1);
        wait_idle(n);
        dchk("same_cyc_write", 2, 0, 4);

        bus.start = 1'b1; bus.write_enable = 1'b1; bus.addr = 5'd25;
        tick;
        bus.start = 1'b0;
        chk("oor_dout", 32'(bus.data_out), 0);
        bus.cont = 1'b1; bus.data_in = 3'd7;
        tick; tick; tick;
        bus.cont = 1'b0; bus.write_enable = 1'b0;
        chk("oor_dout2", 32'(bus.data_out), 0);
        chk("full_mask3", 32'(bus.row_full), (32'd1 << 19) | (32'd1 << 18) | (32'd1 << 6));

        bus.collapse_req = 1'b1; bus.collapse_row = 5'd10;
        tick;
        bus.collapse_req = 1'b0;
        tick; tick;
        chk("c10_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_full", 32'(bus.row_full), 0);
        nz = 0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                bus.disp_row = 5'(r);
                bus.disp_col = 4'(c);
                #1;
                if (bus.disp_data != 3'd0) nz++;
            end
        chk("arst_cells", 32'(nz), 0);
        tick;
        reset = 1'b0;
        tick;
        burst_write(2, 3, -1);
        bus.collapse_req = 1'b1; bus.collapse_row = 5'd2;
        tick;
        bus.collapse_req = 1'b0;
        wait_idle(n);
        chk("post_busy_cycles", 32'(n), 3);
        chk("post_done", 32'(bus.done), 1);
        dchk("post_r2", 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
